// File: rtl/sdprf_fifo_ctrl_if.sv
// Signal bundle between the FIFO controller and its surroundings:
// producer write port, consumer output port, occupancy/status flags
// and the external simple-dual-port RAM connections.
interface sdprf_fifo_ctrl_if #(
    parameter int DW = 22,
    parameter int AW = 4
) ();
    // Producer side
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          ovf;

    // Consumer side (first-word-fall-through)
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    usedw;

    // External RAM write port
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_wraddress;
    logic          ram_wren;

    // External RAM read port (ram_q valid one clock after ram_rden)
    logic [AW-1:0] ram_rdaddress;
    logic          ram_rden;
    logic [DW-1:0] ram_q;

    // Controller view
    modport slave (
        input  wr_en, wr_data, out_ready, ram_q,
        output full, ovf, out_data, out_valid, usedw,
        output ram_data, ram_wraddress, ram_wren,
        output ram_rdaddress, ram_rden
    );

    // Environment view (producer, consumer and RAM)
    modport master (
        output wr_en, wr_data, out_ready, ram_q,
        input  full, ovf, out_data, out_valid, usedw,
        input  ram_data, ram_wraddress, ram_wren,
        input  ram_rdaddress, ram_rden
    );
endinterface

// File: rtl/sdprf_fifo_ctrl.sv
// FIFO controller around an external simple-dual-port RAM with a one-clock
// read latency. A two-entry output stage (head + skid) hides that latency so
// the head word falls through and the FIFO streams one word per clock.
module sdprf_fifo_ctrl #(
    parameter int DW = 22,
    parameter int AW = 4
) (
    input  logic              clock,
    input  logic              sclr,
    sdprf_fifo_ctrl_if.slave  bus
);
    localparam int         DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    // Output stage occupancy: empty, head only, head and skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_BOTH  = 2'd2
    } stage_t;

    stage_t        stage_reg, stage_next;
    logic [DW-1:0] head_reg, head_next;
    logic [DW-1:0] skid_reg, skid_next;

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   ram_cnt_reg, ram_cnt_next;
    logic          inflight_reg;
    logic [4:0]    usedw_reg, usedw_next;
    logic          full_reg;
    logic          ovf_reg;

    logic          pop;
    logic          ram_full;
    logic          wr_accept;
    logic          wr_drop;
    logic          rd_issue;
    logic [1:0]    stage_cnt;
    logic [2:0]    pipe_occ;

    // Handshake decode: accept/drop writes and decide whether a RAM read may
    // be launched. ram_cnt_reg excludes this cycle's write, so a word written
    // now is never read in the same cycle.
    always_comb begin
        pop       = (stage_reg != ST_EMPTY) && bus.out_ready;
        ram_full  = (ram_cnt_reg == DEPTH_CNT);
        wr_accept = !sclr && bus.wr_en && !ram_full;
        wr_drop   = !sclr && bus.wr_en && ram_full;

        stage_cnt = 2'd0;
        case (stage_reg)
            ST_HEAD: stage_cnt = 2'd1;
            ST_BOTH: stage_cnt = 2'd2;
            default: stage_cnt = 2'd0;
        endcase

        // Words that will sit in the output stage once the in-flight read
        // lands and this cycle's pop leaves; a pop implies stage_cnt >= 1.
        pipe_occ = {1'b0, stage_cnt} + {2'b00, inflight_reg} - {2'b00, pop};
        rd_issue = !sclr && (ram_cnt_reg != '0) && (pipe_occ < 3'd2);
    end

    // Output stage next state: the returning RAM word goes to the head when
    // the head is empty or leaving, otherwise into the skid; on a pop the
    // skid word advances to the head to keep FIFO order.
    always_comb begin
        stage_next = stage_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (stage_reg)
            ST_EMPTY: begin
                if (inflight_reg) begin
                    head_next  = bus.ram_q;
                    stage_next = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (pop) begin
                    if (inflight_reg) begin
                        head_next = bus.ram_q;
                    end else begin
                        stage_next = ST_EMPTY;
                    end
                end else if (inflight_reg) begin
                    skid_next  = bus.ram_q;
                    stage_next = ST_BOTH;
                end
            end
            ST_BOTH: begin
                // A read is never launched that could land here without a pop.
                if (pop) begin
                    head_next = skid_reg;
                    if (inflight_reg) begin
                        skid_next = bus.ram_q;
                    end else begin
                        stage_next = ST_HEAD;
                    end
                end
            end
            default: begin
                stage_next = ST_EMPTY;
            end
        endcase
    end

    // Occupancy counters: RAM word count and total words held.
    always_comb begin
        ram_cnt_next = ram_cnt_reg;
        if (wr_accept && !rd_issue) begin
            ram_cnt_next = ram_cnt_reg + 1'b1;
        end else if (!wr_accept && rd_issue) begin
            ram_cnt_next = ram_cnt_reg - 1'b1;
        end

        usedw_next = usedw_reg;
        if (wr_accept && !pop) begin
            usedw_next = usedw_reg + 5'd1;
        end else if (!wr_accept && pop) begin
            usedw_next = usedw_reg - 5'd1;
        end
    end

    // Output stage state and data registers.
    always_ff @(posedge clock) begin
        if (sclr) begin
            stage_reg <= ST_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            stage_reg <= stage_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    // Pointers, counters and flags. Clearing inflight discards any word
    // returning from a read issued just before reset.
    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            usedw_reg    <= '0;
            full_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            ram_cnt_reg  <= ram_cnt_next;
            inflight_reg <= rd_issue;
            usedw_reg    <= usedw_next;
            full_reg     <= (ram_cnt_next == DEPTH_CNT);
            ovf_reg      <= ovf_reg || wr_drop;
        end
    end

    assign bus.full          = full_reg;
    assign bus.ovf           = ovf_reg;
    assign bus.out_data      = head_reg;
    assign bus.out_valid     = (stage_reg != ST_EMPTY);
    assign bus.usedw         = usedw_reg;
    assign bus.ram_data      = bus.wr_data;
    assign bus.ram_wraddress = wr_ptr_reg;
    assign bus.ram_wren      = wr_accept;
    assign bus.ram_rdaddress = rd_ptr_reg;
    assign bus.ram_rden      = rd_issue;

    // The output stage plus an in-flight read never exceeds two words.
    a_stage_bound: assert property (@(posedge clock) disable iff (sclr)
        ({1'b0, stage_cnt} + {2'b00, inflight_reg}) <= 3'd2);

    // usedw always equals the sum of words in RAM, in flight and staged.
    a_usedw_sum: assert property (@(posedge clock) disable iff (sclr)
        usedw_reg == (5'(ram_cnt_reg) + 5'(stage_cnt) + 5'(inflight_reg)));
endmodule

// File: tb/tb_sdprf_fifo_ctrl.sv
// Scoreboard bench for sdprf_fifo_ctrl: stimulus pushes expected words into
// a queue, a negedge monitor pops and compares on every accepted output.
module tb_sdprf_fifo_ctrl;
    localparam int DW = 22;
    localparam int AW = 4;

    logic clock;
    logic sclr;

    sdprf_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    sdprf_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clock (clock),
        .sclr  (sclr),
        .bus   (bus)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural RAM with one-clock registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
        if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
    end

    int total = 0;
    int bad = 0;
    int n_pops = 0;
    bit mon_en = 1'b1;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare each popped word and check stall stability
    bit hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] exp_word;
    always @(negedge clock) begin
        if (mon_en && !sclr) begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_data", {10'd0, bus.out_data}, {10'd0, hold_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop actual=%h required=none", bus.out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("pop_data", {10'd0, bus.out_data}, {10'd0, exp_word});
                    $display("pop %0d data=%h", n_pops, bus.out_data);
                end
                n_pops++;
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_data    = bus.out_data;
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input bit expect_it);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (expect_it) exp_q.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int start;
        int pushed;
        int bubbles;
        bit seen;

        sclr          = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        sclr = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", {10'd0, bus.out_data}, 32'd0);
        check("rst_usedw", {27'd0, bus.usedw}, 32'd0);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

        // Single word latency
        wr(22'h15A5A, 1'b1);
        check("sw_usedw_c1", {27'd0, bus.usedw}, 32'd1);
        check("sw_valid_c1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("sw_valid_c2", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("sw_valid_c3", {31'd0, bus.out_valid}, 32'd1);
        check("sw_data_c3", {10'd0, bus.out_data}, 32'h15A5A);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("sw_usedw_end", {27'd0, bus.usedw}, 32'd0);

        // Fill: 18 accepted, 19th dropped
        for (int i = 0; i < 18; i++) wr(DW'(i), 1'b1);
        check("fill_full", {31'd0, bus.full}, 32'd1);
        check("fill_usedw", {27'd0, bus.usedw}, 32'd18);
        check("fill_ovf_pre", {31'd0, bus.ovf}, 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 22'h00012;
        #1;
        check("drop_wren", {31'd0, bus.ram_wren}, 32'd0);
        tick();
        bus.wr_en = 1'b0;
        check("drop_ovf", {31'd0, bus.ovf}, 32'd1);
        check("drop_usedw", {27'd0, bus.usedw}, 32'd18);

        // Drain after fill: 18 pops in 18 consecutive cycles
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            check("drain_valid", {31'd0, bus.out_valid}, 32'd1);
            tick();
            if (i == 0) check("drain_full", {31'd0, bus.full}, 32'd0);
        end
        check("drain_valid_end", {31'd0, bus.out_valid}, 32'd0);
        check("drain_usedw_end", {27'd0, bus.usedw}, 32'd0);

        // Streaming 40 words, out_ready held high
        start = n_pops;
        seen = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 80 && (n_pops - start) < 40; i++) begin
            if (i < 40) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = DW'(32'h20000 + i);
                exp_q.push_back(DW'(32'h20000 + i));
            end else begin
                bus.wr_en = 1'b0;
            end
            if (bus.out_valid) seen = 1'b1;
            else if (seen) bubbles++;
            tick();
        end
        bus.wr_en = 1'b0;
        check("stream_pops", n_pops - start, 40);
        check("stream_bubbles", bubbles, 0);

        // Backpressure: 100 words with random out_ready
        start = n_pops;
        pushed = 0;
        for (int cyc = 0; cyc < 3000 && (n_pops - start) < 100; cyc++) begin
            check("bp_usedw", {27'd0, bus.usedw}, pushed - (n_pops - start));
            bus.out_ready = 1'($urandom_range(0, 1));
            if (pushed < 100 && (pushed - (n_pops - start)) < 14) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = DW'(32'h30000 + pushed);
                exp_q.push_back(DW'(32'h30000 + pushed));
                pushed++;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
        end
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_pops", n_pops - start, 100);

        // Reset mid-flight: fill with discarded words, pop once, reset
        mon_en = 1'b0;
        for (int i = 0; i < 19; i++) wr(DW'(32'h3F000 + i), 1'b0);
        check("mf_full", {31'd0, bus.full}, 32'd1);
        check("mf_ovf", {31'd0, bus.ovf}, 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("mf_rden", {31'd0, bus.ram_rden}, 32'd1);
        tick();
        bus.out_ready = 1'b0;
        sclr          = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 22'h3ABCD;
        #1;
        check("mf_sclr_wren", {31'd0, bus.ram_wren}, 32'd0);
        check("mf_sclr_rden", {31'd0, bus.ram_rden}, 32'd0);
        tick();
        sclr      = 1'b0;
        bus.wr_en = 1'b0;
        check("mf_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mf_usedw", {27'd0, bus.usedw}, 32'd0);
        check("mf_full_clr", {31'd0, bus.full}, 32'd0);
        check("mf_ovf_clr", {31'd0, bus.ovf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mf_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        mon_en = 1'b1;
        start = n_pops;
        wr(22'h2BEEF, 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_pops - start) < 1; i++) tick();
        bus.out_ready = 1'b0;
        check("mf_first_pop", n_pops - start, 1);
        tick();
        check("mf_usedw_end", {27'd0, bus.usedw}, 32'd0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
